// File: rtl/qq_mem_pkg.sv
// qq_mem_pkg: shared constants for the BRAM-backed QuickQ queue.
// Holds output-buffer depth, RAM read latency and the count-width helper.
package qq_mem_pkg;

    localparam int OB_DEPTH = 2;
    localparam int RD_LAT   = 1;

    // Width needed to hold 0..d inclusive.
    function automatic int cnt_w(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/fifo_obuf2.sv
// fifo_obuf2: 2-entry output buffer that absorbs RAM read latency.
// Ports: clk, rst_n (sync), flush, push/push_data, pop, head, cnt.
module fifo_obuf2
    import qq_mem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   cnt
);

    logic [W-1:0] mem [OB_DEPTH];
    logic         hd;
    logic         tl;

    // Tail slot sits one past head when one entry is held.
    assign tl   = hd ^ cnt[0];
    assign head = mem[hd];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            hd  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (push) begin
                mem[tl] <= push_data;
            end
            if (pop) begin
                hd <= ~hd;
            end
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/mem2p_fifo_ctrl.sv
// mem2p_fifo_ctrl: FIFO controller sequencing an external two-port RAM.
// Ports: clk, rst_n, clr, in_* push side, out_* pop side,
//        ram_* RAM write/read port, count/empty/full status.
module mem2p_fifo_ctrl
    import qq_mem_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 128,
    localparam int DW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          ram_we,
    output logic [DW-1:0] ram_waddr,
    output logic [W-1:0]  ram_wdata,
    output logic [DW-1:0] ram_raddr,
    input  logic [W-1:0]  ram_rdata,
    output logic [DW:0]   count,
    output logic          empty,
    output logic          full
);

    localparam int            CW    = cnt_w(D);
    localparam int            OCC_W = $clog2(OB_DEPTH + RD_LAT + 1);
    localparam logic [CW-1:0] CAP   = CW'(D);

    logic [DW-1:0]    wptr;
    logic [DW-1:0]    rptr;
    logic [CW-1:0]    ram_cnt;
    logic             inflight;
    logic [1:0]       ob_cnt;
    logic [OCC_W-1:0] occ;
    logic             flush;
    logic             push_fire;
    logic             pop_fire;
    logic             rd_issue;

    assign flush     = !rst_n || clr;
    assign in_ready  = !flush && (count < CAP);
    assign push_fire = in_valid && in_ready;
    assign out_valid = ob_cnt != 2'd0;
    assign pop_fire  = !flush && out_valid && out_ready;

    // Buffer slots committed after this cycle's pop; a new read is
    // only issued when its return is guaranteed a free slot.
    assign occ = OCC_W'(ob_cnt) + OCC_W'(inflight) - OCC_W'(pop_fire);

    // ram_cnt only counts entries whose write edge has passed, so a
    // read can never hit the address being written this cycle.
    assign rd_issue = !flush && (ram_cnt != '0)
                      && (occ < OCC_W'(OB_DEPTH));

    assign ram_we    = push_fire;
    assign ram_waddr = wptr;
    assign ram_wdata = in_data;
    assign ram_raddr = rptr;

    assign empty = count == '0;
    assign full  = count == CAP;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            count    <= '0;
        end else begin
            if (push_fire) begin
                wptr <= wptr + DW'(1);
            end
            if (rd_issue) begin
                rptr <= rptr + DW'(1);
            end
            ram_cnt  <= ram_cnt + CW'(push_fire) - CW'(rd_issue);
            inflight <= rd_issue;
            count    <= count + CW'(push_fire) - CW'(pop_fire);
        end
    end

    // Returning data is dropped while flushing so stale reads vanish.
    fifo_obuf2 #(
        .W (W)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (clr),
        .push      (inflight && !flush),
        .push_data (ram_rdata),
        .pop       (pop_fire),
        .head      (out_data),
        .cnt       (ob_cnt)
    );

endmodule

// File: tb/tb_mem2p_fifo_ctrl.sv
// tb_mem2p_fifo_ctrl: directed bench with a queue scoreboard.
// A bench-side RAM model backs the controller (D=8, W=8).
module tb_mem2p_fifo_ctrl;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int DW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          ram_we;
    logic [DW-1:0] ram_waddr;
    logic [W-1:0]  ram_wdata;
    logic [DW-1:0] ram_raddr;
    logic [W-1:0]  ram_rdata;
    logic [DW:0]   count;
    logic          empty;
    logic          full;

    int nvec = 0;
    int nerr = 0;

    logic [W-1:0] sbq [$];
    logic [W-1:0] ram [D];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        ram_rdata <= ram[ram_raddr];
    end

    mem2p_fifo_ctrl #(
        .W (W),
        .D (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every pop the DUT performs is checked against the queue.
    always @(negedge clk) begin
        if (rst_n && !clr && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL sb_unexpected: got %0h, expected none",
                         out_data);
            end else begin
                chk("sb_data", 32'(out_data), 32'(sbq.pop_front()));
            end
        end
    end

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (empty) break;
            tick();
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_sb", 32'(sbq.size()), 32'd0);
        out_ready = 1'b0;
        tick();
    endtask

    task automatic push1(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        sbq.push_back(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready_hi", 32'(in_ready), 32'd1);
        tick();

        // Single push latency
        push1(8'hA5);
        @(negedge clk);
        chk("a_we", 32'(ram_we), 32'd1);
        chk("a_waddr", 32'(ram_waddr), 32'd0);
        chk("a_wdata", 32'(ram_wdata), 32'hA5);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            chk("a_not_yet", 32'(out_valid), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("a_valid_c3", 32'(out_valid), 32'd1);
        chk("a_data_c3", 32'(out_data), 32'hA5);
        chk("a_count", 32'(count), 32'd1);
        tick();
        drain();

        // Fill to full, 9th push ignored
        for (int i = 1; i <= 8; i++) begin
            push1(8'(i));
            @(negedge clk);
            chk("b_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 8'h09;
        @(negedge clk);
        chk("b_full", 32'(full), 32'd1);
        chk("b_in_ready_lo", 32'(in_ready), 32'd0);
        chk("b_we_lo", 32'(ram_we), 32'd0);
        chk("b_count", 32'(count), 32'd8);
        tick();
        in_valid = 1'b0;

        // Pop all on consecutive cycles
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("c_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("c_empty", 32'(empty), 32'd1);
        chk("c_count", 32'(count), 32'd0);
        tick();

        // Full with pop and push in the same cycle
        for (int i = 0; i < 8; i++) begin
            push1(8'(8'h11 + i));
            tick();
        end
        in_valid  = 1'b1;
        in_data   = 8'h99;
        out_ready = 1'b1;
        @(negedge clk);
        chk("f_in_ready_lo", 32'(in_ready), 32'd0);
        chk("f_out_valid", 32'(out_valid), 32'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("f_count", 32'(count), 32'd7);
        chk("f_in_ready_hi", 32'(in_ready), 32'd1);
        tick();
        drain();

        // Streaming 0x00..0x1F, pointers wrap four times
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            push1(8'(i));
            @(negedge clk);
            chk("d_in_ready", 32'(in_ready), 32'd1);
            chk("d_count", 32'(count), 32'(i < 3 ? i : 3));
            if (i >= 3) chk("d_no_gap", 32'(out_valid), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("d_tail", 32'(out_valid), 32'd1);
            tick();
        end
        drain();

        // Reset with count=5 and a read in flight
        for (int i = 0; i < 6; i++) begin
            push1(8'(8'h31 + i));
            out_ready = (i == 5);
            tick();
        end
        out_ready = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        sbq.delete();
        @(negedge clk);
        chk("e_pre_count", 32'(count), 32'd5);
        chk("e_rst_we", 32'(ram_we), 32'd0);
        tick();
        rst_n = 1'b1;
        push1(8'h77);
        @(negedge clk);
        chk("e_count", 32'(count), 32'd0);
        chk("e_out_valid", 32'(out_valid), 32'd0);
        chk("e_we", 32'(ram_we), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            chk("e_stale", 32'(out_valid), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("e_valid_c3", 32'(out_valid), 32'd1);
        chk("e_data_c3", 32'(out_data), 32'h77);
        tick();
        drain();

        // clr flush ignores a same-cycle push and pop
        push1(8'h41);
        tick();
        push1(8'h42);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        clr       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h43;
        out_ready = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("g_in_ready", 32'(in_ready), 32'd0);
        chk("g_we", 32'(ram_we), 32'd0);
        tick();
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("g_count", 32'(count), 32'd0);
        chk("g_out_valid", 32'(out_valid), 32'd0);
        tick();
        push1(8'h44);
        tick();
        in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
